// File: rtl/io_pad_ctrl_pkg.sv
// Shared definitions for the GPIO pad-bank controller: register map and decode selector.
package io_pad_ctrl_pkg;

    localparam int REG_W = 32;

    localparam logic [7:0] ADDR_DOUT       = 8'h00;
    localparam logic [7:0] ADDR_DIN        = 8'h04;
    localparam logic [7:0] ADDR_IRQ_EN     = 8'h08;
    localparam logic [7:0] ADDR_IRQ_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_DEBOUNCE   = 8'h10;
    localparam logic [7:0] ADDR_CFG_BASE   = 8'h40;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DOUT,
        SEL_DIN,
        SEL_IRQ_EN,
        SEL_IRQ_STATUS,
        SEL_DEBOUNCE,
        SEL_CFG
    } regSel_e;

endpackage

// File: rtl/io_pad_debounce.sv
// One pad input: two-flop synchroniser, saturating debounce counter, stable level and rise pulse.
module io_pad_debounce
    import io_pad_ctrl_pkg::*;
#(
    parameter int DB_W = 16
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            i_pad,
    input  logic [DB_W-1:0] i_debounce,
    output logic            o_stable,
    output logic            o_rise
);

    logic            r_sync0;
    logic            r_sync1;
    logic            r_stable;
    logic [DB_W-1:0] r_cnt;
    logic            w_stableNext;
    logic [DB_W-1:0] w_cntNext;

    // The level must disagree with the stable value for DEBOUNCE+1 consecutive cycles to be accepted.
    always_comb begin
        w_stableNext = r_stable;
        w_cntNext    = r_cnt;
        if (r_sync1 == r_stable) begin
            w_cntNext = '0;
        end else if (r_cnt >= i_debounce) begin
            w_stableNext = r_sync1;
            w_cntNext    = '0;
        end else if (r_cnt != '1) begin
            w_cntNext = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync0  <= i_pad;
            r_sync1  <= r_sync0;
            r_stable <= w_stableNext;
            r_cnt    <= w_cntNext;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_stableNext & ~r_stable;

endmodule

// File: rtl/io_pad_ctrl.sv
// Core-side controller for one GPIO pad bank: register file, pad config/outputs, debounced inputs, IRQ.
module io_pad_ctrl
    import io_pad_ctrl_pkg::*;
#(
    parameter int                      NUM_PINS     = 8,
    parameter int                      IOCELL_CFG_W = 3,
    parameter logic [IOCELL_CFG_W-1:0] CFG_RESET    = '0,
    parameter int                      DB_W         = 16
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             reg_req,
    input  logic                             reg_we,
    input  logic [7:0]                       reg_addr,
    input  logic [31:0]                      reg_wdata,
    output logic [31:0]                      reg_rdata,
    output logic                             reg_ack,
    output logic [NUM_PINS*IOCELL_CFG_W-1:0] io_cell_cfg_out,
    output logic [NUM_PINS-1:0]              from_core_out,
    input  logic [NUM_PINS-1:0]              to_core_in,
    output logic                             irq_out
);

    localparam logic [6:0] NUM_PINS_W = 7'(NUM_PINS);

    logic [NUM_PINS-1:0]              r_dout;
    logic [NUM_PINS-1:0]              r_irqEn;
    logic [NUM_PINS-1:0]              r_irqStatus;
    logic [DB_W-1:0]                  r_debounce;
    logic [NUM_PINS*IOCELL_CFG_W-1:0] r_cfg;
    logic                             r_ack;
    logic [REG_W-1:0]                 r_rdata;
    logic                             r_irq;

    logic [5:0]          w_wordAddr;
    logic [5:0]          w_cfgOffset;
    regSel_e             w_sel;
    logic                w_wr;
    logic [REG_W-1:0]    w_rdata;
    logic [NUM_PINS-1:0] w_w1cMask;
    logic [NUM_PINS-1:0] w_din;
    logic [NUM_PINS-1:0] w_rise;
    logic                w_unused;

    assign w_wordAddr  = reg_addr[7:2];
    assign w_cfgOffset = w_wordAddr - ADDR_CFG_BASE[7:2];
    assign w_wr        = reg_req & reg_we;
    assign w_unused    = &{1'b0, reg_addr[1:0], reg_wdata};

    generate
        for (genvar k = 0; k < NUM_PINS; k++) begin : g_pin
            io_pad_debounce #(.DB_W(DB_W)) u_debounce (
                .clk_in     (clk_in),
                .reset_in   (reset_in),
                .i_pad      (to_core_in[k]),
                .i_debounce (r_debounce),
                .o_stable   (w_din[k]),
                .o_rise     (w_rise[k])
            );
        end
    endgenerate

    // Address decode and read mux; anything unmapped reads as zero.
    always_comb begin
        w_sel     = SEL_NONE;
        w_rdata   = '0;
        w_w1cMask = '0;
        if (w_wordAddr == ADDR_DOUT[7:2])            w_sel = SEL_DOUT;
        else if (w_wordAddr == ADDR_DIN[7:2])        w_sel = SEL_DIN;
        else if (w_wordAddr == ADDR_IRQ_EN[7:2])     w_sel = SEL_IRQ_EN;
        else if (w_wordAddr == ADDR_IRQ_STATUS[7:2]) w_sel = SEL_IRQ_STATUS;
        else if (w_wordAddr == ADDR_DEBOUNCE[7:2])   w_sel = SEL_DEBOUNCE;
        else if ((w_wordAddr >= ADDR_CFG_BASE[7:2]) && ({1'b0, w_cfgOffset} < NUM_PINS_W))
            w_sel = SEL_CFG;

        case (w_sel)
            SEL_DOUT:       w_rdata[NUM_PINS-1:0] = r_dout;
            SEL_DIN:        w_rdata[NUM_PINS-1:0] = w_din;
            SEL_IRQ_EN:     w_rdata[NUM_PINS-1:0] = r_irqEn;
            SEL_IRQ_STATUS: w_rdata[NUM_PINS-1:0] = r_irqStatus;
            SEL_DEBOUNCE:   w_rdata[DB_W-1:0]     = r_debounce;
            SEL_CFG: begin
                for (int k = 0; k < NUM_PINS; k++) begin
                    if (w_cfgOffset == 6'(k))
                        w_rdata[IOCELL_CFG_W-1:0] = r_cfg[k*IOCELL_CFG_W +: IOCELL_CFG_W];
                end
            end
            default: w_rdata = '0;
        endcase

        if (w_wr && (w_sel == SEL_IRQ_STATUS))
            w_w1cMask = reg_wdata[NUM_PINS-1:0];
    end

    // Writes land on the same edge that raises ack; a new rise beats a simultaneous clear.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_dout      <= '0;
            r_irqEn     <= '0;
            r_irqStatus <= '0;
            r_debounce  <= '0;
            r_cfg       <= {NUM_PINS{CFG_RESET}};
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_ack   <= reg_req;
            r_rdata <= (reg_req && !reg_we) ? w_rdata : '0;
            if (w_wr && (w_sel == SEL_DOUT))     r_dout     <= reg_wdata[NUM_PINS-1:0];
            if (w_wr && (w_sel == SEL_IRQ_EN))   r_irqEn    <= reg_wdata[NUM_PINS-1:0];
            if (w_wr && (w_sel == SEL_DEBOUNCE)) r_debounce <= reg_wdata[DB_W-1:0];
            for (int k = 0; k < NUM_PINS; k++) begin
                if (w_wr && (w_sel == SEL_CFG) && (w_cfgOffset == 6'(k)))
                    r_cfg[k*IOCELL_CFG_W +: IOCELL_CFG_W] <= reg_wdata[IOCELL_CFG_W-1:0];
            end
            r_irqStatus <= (r_irqStatus & ~w_w1cMask) | w_rise;
            r_irq       <= |(r_irqStatus & r_irqEn);
        end
    end

    assign reg_ack         = r_ack;
    assign reg_rdata       = r_rdata;
    assign from_core_out   = r_dout;
    assign io_cell_cfg_out = r_cfg;
    assign irq_out         = r_irq;

endmodule

// File: tb/tb_io_pad_ctrl.sv
// Directed self-checking bench for io_pad_ctrl: registers, pad config, debounce timing, IRQ, reset.
module tb_io_pad_ctrl;

    logic        clk_in;
    logic        reset_in;
    logic        reg_req;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic [23:0] io_cell_cfg_out;
    logic [7:0]  from_core_out;
    logic [7:0]  to_core_in;
    logic        irq_out;

    int nChecks = 0;
    int nPass   = 0;

    io_pad_ctrl #(
        .NUM_PINS     (8),
        .IOCELL_CFG_W (3),
        .CFG_RESET    (3'b010),
        .DB_W         (16)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .reg_req         (reg_req),
        .reg_we          (reg_we),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .reg_ack         (reg_ack),
        .io_cell_cfg_out (io_cell_cfg_out),
        .from_core_out   (from_core_out),
        .to_core_in      (to_core_in),
        .irq_out         (irq_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // One bus access; returns ack and rdata sampled just after the ack edge.
    task automatic busOp(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                         output logic ack, output logic [31:0] rdata);
        @(negedge clk_in);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        @(posedge clk_in);
        #1;
        ack     = reg_ack;
        rdata   = reg_rdata;
        reg_req = 1'b0;
        reg_we  = 1'b0;
    endtask

    task automatic test_reset;
        logic        ack;
        logic [31:0] rd;
        logic [7:0]  addrs [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
        reset_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        nChecks++;
        if (reg_ack !== 1'b0 || reg_rdata !== 32'h0 || irq_out !== 1'b0)
            $display("[TB] FAIL reset_outs got ack=%0b rdata=%h irq=%0b want 0/0/0", reg_ack, reg_rdata, irq_out);
        else nPass++;
        nChecks++;
        if (from_core_out !== 8'h00 || io_cell_cfg_out !== {8{3'b010}})
            $display("[TB] FAIL reset_pads got dout=%h cfg=%h want 00/%h", from_core_out, io_cell_cfg_out, {8{3'b010}});
        else nPass++;
        @(negedge clk_in);
        reset_in = 1'b0;
        foreach (addrs[i]) begin
            busOp(1'b0, addrs[i], 32'h0, ack, rd);
            nChecks++;
            if (ack !== 1'b1 || rd !== 32'h0)
                $display("[TB] FAIL reset_reg_%h got ack=%0b rdata=%h want 1/0", addrs[i], ack, rd);
            else nPass++;
        end
        for (int k = 0; k < 8; k++) begin
            busOp(1'b0, 8'(8'h40 + 4*k), 32'h0, ack, rd);
            nChecks++;
            if (ack !== 1'b1 || rd !== 32'h2)
                $display("[TB] FAIL reset_cfg%0d got ack=%0b rdata=%h want 1/2", k, ack, rd);
            else nPass++;
        end
    endtask

    task automatic test_write;
        logic        ack;
        logic [31:0] rd;
        logic [23:0] expCfg;
        expCfg        = {8{3'b010}};
        expCfg[11:9]  = 3'b101;
        busOp(1'b1, 8'h00, 32'h1234_56A5, ack, rd);
        nChecks++;
        if (from_core_out !== 8'hA5)
            $display("[TB] FAIL dout_pads got %h want a5", from_core_out);
        else nPass++;
        busOp(1'b1, 8'h4C, 32'hFFFF_FFFD, ack, rd);
        nChecks++;
        if (io_cell_cfg_out !== expCfg)
            $display("[TB] FAIL cfg3_pads got %h want %h", io_cell_cfg_out, expCfg);
        else nPass++;
        busOp(1'b0, 8'h00, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h0000_00A5)
            $display("[TB] FAIL dout_read got %h want 000000a5", rd);
        else nPass++;
        busOp(1'b0, 8'h4F, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h0000_0005)
            $display("[TB] FAIL cfg3_read got %h want 00000005", rd);
        else nPass++;
    endtask

    task automatic test_debounce;
        logic        ack;
        logic [31:0] rd;
        int          highSeen;
        int          first;
        busOp(1'b1, 8'h10, 32'd4, ack, rd);
        busOp(1'b0, 8'h10, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'd4)
            $display("[TB] FAIL debounce_read got %h want 4", rd);
        else nPass++;

        // Stream DIN reads; each rdata shows DIN as it was one edge earlier.
        @(negedge clk_in);
        reg_req  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = 8'h04;
        @(posedge clk_in);
        #1;
        to_core_in[0] = 1'b1;
        highSeen = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk_in);
            #1;
            if (i == 3) to_core_in[0] = 1'b0;
            if (reg_rdata[0] === 1'b1) highSeen++;
        end
        nChecks++;
        if (highSeen != 0)
            $display("[TB] FAIL glitch_din got %0d high cycles want 0", highSeen);
        else nPass++;

        to_core_in[0] = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_in);
            #1;
            if (first == 0 && reg_rdata[0] === 1'b1) first = i;
        end
        reg_req = 1'b0;
        nChecks++;
        if (first != 8)
            $display("[TB] FAIL din_latency got read edge %0d want 8 (DIN at edge 7)", first);
        else nPass++;

        busOp(1'b0, 8'h0C, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h1 || irq_out !== 1'b0)
            $display("[TB] FAIL rise_status got status=%h irq=%0b want 1/0", rd, irq_out);
        else nPass++;
    endtask

    task automatic test_irq;
        logic        ack;
        logic [31:0] rd;
        int          first;
        busOp(1'b1, 8'h10, 32'd0, ack, rd);
        busOp(1'b1, 8'h08, 32'h1, ack, rd);
        busOp(1'b1, 8'h0C, 32'h1, ack, rd);
        nChecks++;
        if (irq_out !== 1'b1)
            $display("[TB] FAIL irq_pre_clear got %0b want 1", irq_out);
        else nPass++;
        @(posedge clk_in);
        #1;
        nChecks++;
        if (irq_out !== 1'b0)
            $display("[TB] FAIL irq_after_clear got %0b want 0", irq_out);
        else nPass++;

        to_core_in[0] = 1'b0;
        repeat (6) @(posedge clk_in);
        busOp(1'b0, 8'h0C, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h0)
            $display("[TB] FAIL fall_status got %h want 0", rd);
        else nPass++;

        @(posedge clk_in);
        #1;
        to_core_in[0] = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_in);
            #1;
            if (first == 0 && irq_out === 1'b1) first = i;
        end
        nChecks++;
        if (first != 4)
            $display("[TB] FAIL irq_latency got edge %0d want 4", first);
        else nPass++;

        @(negedge clk_in);
        reg_req   = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = 8'h0C;
        reg_wdata = 32'h1;
        @(posedge clk_in);
        #1;
        reg_req = 1'b0;
        reg_we  = 1'b0;
        nChecks++;
        if (irq_out !== 1'b1)
            $display("[TB] FAIL irq_at_w1c got %0b want 1", irq_out);
        else nPass++;
        @(posedge clk_in);
        #1;
        nChecks++;
        if (irq_out !== 1'b0)
            $display("[TB] FAIL irq_post_w1c got %0b want 0", irq_out);
        else nPass++;

        // Clear on exactly the edge where a fresh rise is recorded: the rise must survive.
        to_core_in[0] = 1'b0;
        repeat (6) @(posedge clk_in);
        @(posedge clk_in);
        #1;
        to_core_in[0] = 1'b1;
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        reg_req   = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = 8'h0C;
        reg_wdata = 32'h1;
        @(posedge clk_in);
        #1;
        reg_req = 1'b0;
        reg_we  = 1'b0;
        busOp(1'b0, 8'h0C, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h1)
            $display("[TB] FAIL w1c_vs_rise got status=%h want 1", rd);
        else nPass++;
        nChecks++;
        if (irq_out !== 1'b1)
            $display("[TB] FAIL w1c_vs_rise_irq got %0b want 1", irq_out);
        else nPass++;
    endtask

    task automatic test_unmapped;
        logic        ack;
        logic [31:0] rd;
        busOp(1'b0, 8'h20, 32'h0, ack, rd);
        nChecks++;
        if (ack !== 1'b1 || rd !== 32'h0)
            $display("[TB] FAIL unmapped_read got ack=%0b rdata=%h want 1/0", ack, rd);
        else nPass++;
        busOp(1'b1, 8'h04, 32'h0, ack, rd);
        nChecks++;
        if (ack !== 1'b1)
            $display("[TB] FAIL din_write_ack got %0b want 1", ack);
        else nPass++;
        busOp(1'b0, 8'h04, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h1)
            $display("[TB] FAIL din_after_write got %h want 1", rd);
        else nPass++;
        busOp(1'b0, 8'h60, 32'h0, ack, rd);
        nChecks++;
        if (ack !== 1'b1 || rd !== 32'h0)
            $display("[TB] FAIL cfg_out_of_range got ack=%0b rdata=%h want 1/0", ack, rd);
        else nPass++;
        busOp(1'b0, 8'h00, 32'h0, ack, rd);
        @(posedge clk_in);
        #1;
        nChecks++;
        if (reg_ack !== 1'b0 || reg_rdata !== 32'h0)
            $display("[TB] FAIL idle_bus got ack=%0b rdata=%h want 0/0", reg_ack, reg_rdata);
        else nPass++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk_in);
        reg_req  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = 8'h00;
        @(posedge clk_in);
        #1;
        nChecks++;
        if (reg_ack !== 1'b1 || reg_rdata !== 32'hA5)
            $display("[TB] FAIL b2b_first got ack=%0b rdata=%h want 1/a5", reg_ack, reg_rdata);
        else nPass++;
        reg_addr = 8'h08;
        @(posedge clk_in);
        #1;
        reg_req = 1'b0;
        nChecks++;
        if (reg_ack !== 1'b1 || reg_rdata !== 32'h1)
            $display("[TB] FAIL b2b_second got ack=%0b rdata=%h want 1/1", reg_ack, reg_rdata);
        else nPass++;
    endtask

    task automatic test_reset_mid;
        logic        ack;
        logic [31:0] rd;
        busOp(1'b1, 8'h10, 32'd8, ack, rd);
        @(posedge clk_in);
        #1;
        to_core_in[1] = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        reg_req    = 1'b1;
        reg_we     = 1'b0;
        reg_addr   = 8'h04;
        reset_in   = 1'b1;
        to_core_in = 8'h00;
        @(posedge clk_in);
        #1;
        reg_req = 1'b0;
        nChecks++;
        if (reg_ack !== 1'b0 || reg_rdata !== 32'h0)
            $display("[TB] FAIL reset_drops_ack got ack=%0b rdata=%h want 0/0", reg_ack, reg_rdata);
        else nPass++;
        @(posedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b0;
        busOp(1'b0, 8'h04, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h0)
            $display("[TB] FAIL post_reset_din got %h want 0", rd);
        else nPass++;
        busOp(1'b0, 8'h0C, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h0 || irq_out !== 1'b0)
            $display("[TB] FAIL post_reset_status got status=%h irq=%0b want 0/0", rd, irq_out);
        else nPass++;
        busOp(1'b0, 8'h10, 32'h0, ack, rd);
        nChecks++;
        if (rd !== 32'h0 || from_core_out !== 8'h00)
            $display("[TB] FAIL post_reset_regs got debounce=%h dout=%h want 0/00", rd, from_core_out);
        else nPass++;
    endtask

    initial begin
        reset_in   = 1'b1;
        reg_req    = 1'b0;
        reg_we     = 1'b0;
        reg_addr   = 8'h00;
        reg_wdata  = 32'h0;
        to_core_in = 8'h00;
        test_reset();
        test_write();
        test_debounce();
        test_irq();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
